// File: rtl/alu_op_sequencer.sv
// Issue/collect front end for the datapath ALU: registers one operation onto the ALU bus,
// waits a per-opcode settle time, then holds the captured result under a valid/ready response.
module alu_op_sequencer #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_opcode,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_hi,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_lo,
   output logic [WIDTH-1:0] rsp_hi,
   output logic             rsp_carry,
   output logic             rsp_overflow,
   output logic             rsp_err,
   output logic             busy,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_cnt;
   logic [7:0]       w_lat;
   logic [WIDTH-1:0] r_a, r_b, r_lo, r_hi;
   logic [3:0]       r_op;
   logic             r_carry, r_ovf, r_err;
   logic [15:0]      r_op_count;
   logic             w_accept, w_capture, w_handshake, w_b_zero;
   logic [WIDTH-1:0] w_lo, w_hi;
   logic             w_carry, w_ovf, w_err;

   assign w_accept    = (r_state == S_IDLE) && req_valid;
   assign w_capture   = (r_state == S_EXEC) && (r_cnt == 8'd1);
   assign w_handshake = (r_state == S_RESP) && rsp_ready;
   assign w_b_zero    = (r_b == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)    w_next = S_EXEC;
         S_EXEC:  if (w_capture)   w_next = S_RESP;
         S_RESP:  if (w_handshake) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Divide by zero and illegal opcodes finish in one cycle since the ALU output is ignored.
   always_comb begin
      w_lat = 8'd1;
      case (req_opcode)
         4'b0101:          w_lat = 8'(MUL_LAT);
         4'b0110, 4'b0111: if (req_b != '0) w_lat = 8'(DIV_LAT);
         default:          w_lat = 8'd1;
      endcase
   end

   always_comb begin
      w_lo    = alu_result;
      w_hi    = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      case (r_op)
         4'b0000, 4'b0001, 4'b0010,
         4'b1000, 4'b1001, 4'b1010, 4'b1011: ;
         4'b0011, 4'b0100: begin
            w_carry = alu_carry;
            w_ovf   = alu_overflow;
         end
         4'b0101: w_hi = alu_hi;
         4'b0110: begin
            if (w_b_zero) begin
               w_lo  = '1;
               w_hi  = r_a;
               w_err = 1'b1;
            end else begin
               w_hi = alu_hi;
            end
         end
         4'b0111: begin
            if (w_b_zero) begin
               w_lo  = r_a;
               w_hi  = '1;
               w_err = 1'b1;
            end else begin
               w_hi = alu_hi;
            end
         end
         default: begin
            w_lo  = '0;
            w_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_cnt      <= '0;
         r_lo       <= '0;
         r_hi       <= '0;
         r_carry    <= 1'b0;
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
         r_op_count <= '0;
      end else begin
         if (w_accept) begin
            r_a   <= req_a;
            r_b   <= req_b;
            r_op  <= req_opcode;
            r_cnt <= w_lat;
         end else if (r_state == S_EXEC && !w_capture) begin
            r_cnt <= r_cnt - 8'd1;
         end
         if (w_capture) begin
            r_lo    <= w_lo;
            r_hi    <= w_hi;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_err   <= w_err;
         end
         if (w_handshake) r_op_count <= r_op_count + 16'd1;
      end
   end

   assign req_ready    = (r_state == S_IDLE);
   assign rsp_valid    = (r_state == S_RESP);
   assign busy         = (r_state != S_IDLE);
   assign alu_a        = r_a;
   assign alu_b        = r_b;
   assign alu_opcode   = r_op;
   assign rsp_lo       = r_lo;
   assign rsp_hi       = r_hi;
   assign rsp_carry    = r_carry;
   assign rsp_overflow = r_ovf;
   assign rsp_err      = r_err;
   assign op_count     = r_op_count;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential issue/collect front end for the datapath ALU. It accepts one operation at a time over a valid/ready request channel and registers the operands and opcode onto the ALU input bus. It waits a fixed, per-opcode number of cycles for the combinational or multi-cycle units to settle, then captures result, high word and flags into a response register held under a valid/ready response channel. It is the initiator/collector side of the ALU operand/result interface.

## Interface
- WIDTH, 32, operand/result width
- MUL_LAT, 4, cycles to wait for opcode 0101 (multiply), range 1..255
- DIV_LAT, 33, cycles to wait for opcodes 0110/0111 (divide/remainder), range 1..255
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_opcode  in  4  ALU opcode: 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB, 0101 MUL, 0110 DIV, 0111 REM, 1000 SHL, 1001 SHR, 1010 ROL, 1011 ROR
- req_a, req_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_opcode  out  4  registered opcode to ALU
- alu_result  in  WIDTH  ALU primary result
- alu_hi  in  WIDTH  ALU secondary result: upper product for MUL, remainder for DIV, quotient for REM
- alu_carry, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_lo, rsp_hi  out  WIDTH  captured result words
- rsp_carry, rsp_overflow, rsp_err  out  1  captured flags
- busy  out  1  state != IDLE
- op_count  out  16  completed-response counter

## Operation
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- IDLE: req_ready=1. On req_valid (accept edge): load alu_a/alu_b/alu_opcode from the request; load wait counter L; go EXEC.
- L: 1 for opcodes 0000-0100 and 1000-1011; MUL_LAT for 0101; DIV_LAT for 0110/0111; 1 for illegal opcodes 1100-1111; 1 for 0110/0111 with req_b==0.
- EXEC: counter decrements each edge; on the edge where counter==1, capture into response registers and go RESP.
- Capture rules:
  - rsp_lo = alu_result.
  - rsp_hi = alu_hi for 0101/0110/0111, else 0.
  - rsp_carry/rsp_overflow = ALU flags for 0011/0100 only, else 0.
  - rsp_err = 0.
- Illegal opcode capture: rsp_lo=0, rsp_hi=0, flags 0, rsp_err=1. alu_opcode is still driven.
- Divide by zero (0110/0111, b==0) capture:
  - ALU output ignored; rsp_err=1, flags 0.
  - 0110: rsp_lo=all ones, rsp_hi=alu_a.
  - 0111: rsp_lo=alu_a, rsp_hi=all ones.
- RESP: rsp_valid=1; all rsp_* stable until the handshake edge (rsp_valid & rsp_ready). On handshake: op_count += 1 (wraps 0xFFFF→0x0000), go IDLE.
- req_ready=0 in EXEC and RESP; requests there are not accepted and must be held by the source.
- alu_a/alu_b/alu_opcode hold their last value after RESP until the next accept.

## Timing
- Reset (async assert): state IDLE, all outputs 0 except req_ready=1. Includes alu_*, rsp_*, op_count, busy. Any in-flight operation is discarded and no response is produced.
- Accept at edge E0. Capture at edge E0+L. rsp_valid is high from E0+L.
- Earliest next accept is the edge after the handshake edge. Single-cycle op throughput is 1 per 3 cycles when rsp_ready=1.
- busy rises after E0 and falls after the handshake edge.
- The ALU inputs are stable for exactly L cycles before capture.

## Test plan
- ADD 0xFFFFFFFF+1, rsp_ready=1, ALU model returns 0/carry=1:
  - rsp_valid 1 cycle after accept.
  - rsp_lo=0, rsp_carry=1, rsp_hi=0, op_count=1.
- MUL 0x10000×0x10000 with MUL_LAT=4, ALU model alu_hi=1, alu_result=0:
  - rsp_valid exactly 4 edges after accept.
  - rsp_hi=1, rsp_lo=0; alu_a/alu_b held constant throughout.
- DIV 7/0 and REM 7/0:
  - Each responds after 1 cycle with rsp_err=1.
  - DIV: rsp_lo=0xFFFFFFFF, rsp_hi=7.
  - REM: rsp_lo=7, rsp_hi=0xFFFFFFFF.
- Opcode 1101:
  - rsp_err=1, rsp_lo=rsp_hi=0.
  - Next valid request (AND 0xF0&0x3C) returns 0x30 with rsp_err=0.
- Backpressure: rsp_ready=0 for 10 cycles with req_valid held high.
  - rsp_* stable throughout, req_ready=0.
  - Second request accepted on the edge after rsp_ready rises (the edge following the handshake).
- rst asserted mid-DIV (counter=20):
  - All outputs 0 and req_ready=1 immediately; no response appears.
  - op_count preset to 0xFFFF by 65535 ops then one more completed op → 0x0000.
